// File: rtl/emu_step_ctrl_if.sv
// emu_step_ctrl_if: VIO and analog-model signals of the emulator step controller.
// Ports carried (slave = controller view):
//   in : go_vio, rst_vio (async VIO requests), v_in_vio (stimulus), v_out_model (model output)
//   out: model_rst, model_ce, v_in_model, v_out_vio, step_count, busy, missed_go
interface emu_step_ctrl_if #(
  parameter int WIDTH     = 25,
  parameter int CNT_WIDTH = 32
);
  logic                    go_vio;
  logic                    rst_vio;
  logic signed [WIDTH-1:0] v_in_vio;
  logic signed [WIDTH-1:0] v_out_model;
  logic                    model_rst;
  logic                    model_ce;
  logic signed [WIDTH-1:0] v_in_model;
  logic signed [WIDTH-1:0] v_out_vio;
  logic [CNT_WIDTH-1:0]    step_count;
  logic                    busy;
  logic                    missed_go;
  modport master (
    output go_vio, rst_vio, v_in_vio, v_out_model,
    input  model_rst, model_ce, v_in_model, v_out_vio, step_count, busy, missed_go
  );
  modport slave (
    input  go_vio, rst_vio, v_in_vio, v_out_model,
    output model_rst, model_ce, v_in_model, v_out_vio, step_count, busy, missed_go
  );
endinterface

// File: rtl/emu_step_ctrl.sv
// emu_step_ctrl: single-step controller between VIO and an emulated analog model.
// Ports: emu_clk (clock), emu_rst (async active-high reset),
//   bus (emu_step_ctrl_if.slave): VIO go/rst/stimulus in, model step/reset/stimulus out,
//   captured output, step counter, busy and sticky missed_go status.
module emu_step_ctrl #(
  parameter int WIDTH         = 25,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 32
) (
  input logic           emu_clk,
  input logic           emu_rst,
  emu_step_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STEP, SETTLE, CAPTURE} state_t;
  state_t                  state, next;
  logic [SYNC_STAGES-1:0]  go_sync, rst_sync, fill;
  logic                    go_s, rst_s, go_prev, armed, go_edge, missed;
  logic [7:0]              settle_cnt;
  logic signed [WIDTH-1:0] v_in_model, v_out_vio;
  logic [CNT_WIDTH-1:0]    step_count;
  assign go_s  = go_sync[SYNC_STAGES-1];
  assign rst_s = rst_sync[SYNC_STAGES-1];
  // fill marks when the go chain holds real samples; armed requires go to be seen low
  // afterwards, so a go_vio already high across reset release never counts as an edge
  assign go_edge = armed & go_s & ~go_prev;
  always_ff @(posedge emu_clk or posedge emu_rst)
    if (emu_rst) begin
      go_sync    <= '0;
      rst_sync   <= '1;
      fill       <= '0;
      armed      <= 1'b0;
      go_prev    <= 1'b0;
      state      <= IDLE;
      settle_cnt <= '0;
      v_in_model <= '0;
      v_out_vio  <= '0;
      step_count <= '0;
      missed     <= 1'b0;
    end else begin
      go_sync    <= {go_sync[SYNC_STAGES-2:0], bus.go_vio};
      rst_sync   <= {rst_sync[SYNC_STAGES-2:0], bus.rst_vio};
      fill       <= {fill[SYNC_STAGES-2:0], 1'b1};
      armed      <= armed | (fill[SYNC_STAGES-1] & ~go_s);
      go_prev    <= go_s;
      state      <= next;
      settle_cnt <= state == STEP ? 8'(SETTLE_CYCLES - 1) : settle_cnt - 8'(settle_cnt != 0);
      if (state == IDLE && go_edge) v_in_model <= bus.v_in_vio;
      if (state == CAPTURE) v_out_vio <= bus.v_out_model;
      step_count <= rst_s ? '0 : step_count + CNT_WIDTH'(state == CAPTURE && !(&step_count));
      missed     <= rst_s ? 1'b0 : missed | (go_edge & state != IDLE);
    end
  always_comb begin
    next = state;
    next = state == IDLE   ? (go_edge ? STEP : IDLE) :
           state == STEP   ? SETTLE :
           state == SETTLE ? (settle_cnt == 0 ? CAPTURE : SETTLE) : IDLE;
  end
  assign bus.model_rst  = rst_s;
  assign bus.model_ce   = state == STEP;
  assign bus.busy       = state != IDLE;
  assign bus.missed_go  = missed;
  assign bus.v_in_model = v_in_model;
  assign bus.v_out_vio  = v_out_vio;
  assign bus.step_count = step_count;
endmodule

// File: tb/tb_emu_step_ctrl.sv
// tb_emu_step_ctrl: directed self-checking bench for emu_step_ctrl.
module tb_emu_step_ctrl;
  localparam int W = 25;
  localparam logic signed [W-1:0] ONE  = 25'sh0100000;
  localparam logic signed [W-1:0] HALF = 25'sh0080000;
  localparam logic signed [W-1:0] QNEG = 25'sh1FC0000;
  logic emu_clk = 1'b0;
  logic emu_rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 emu_clk = ~emu_clk;
  emu_step_ctrl_if #(.WIDTH(W), .CNT_WIDTH(32)) b ();
  emu_step_ctrl_if #(.WIDTH(W), .CNT_WIDTH(4))  b4 ();
  emu_step_ctrl #(.WIDTH(W), .CNT_WIDTH(32)) u (.emu_clk(emu_clk), .emu_rst(emu_rst), .bus(b.slave));
  emu_step_ctrl #(.WIDTH(W), .CNT_WIDTH(4))  u4 (.emu_clk(emu_clk), .emu_rst(emu_rst), .bus(b4.slave));
  task automatic tick;
    @(posedge emu_clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (3) tick;
    checks++;
    if ({b.model_rst, b.model_ce, b.busy, b.missed_go} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=1000", {b.model_rst, b.model_ce, b.busy, b.missed_go});
    end
    checks++;
    if (b.v_in_model !== 0 || b.v_out_vio !== 0 || b.step_count !== 0) begin
      failures++;
      $display("FAIL reset_data got vin=%0h vout=%0h cnt=%0d exp 0", b.v_in_model, b.v_out_vio, b.step_count);
    end
    emu_rst = 1'b0;
    repeat (5) tick;
  endtask
  task automatic test_latency;
    int first = -1, nce = 0, nbusy = 0, upd = -1;
    b.v_in_vio = ONE;
    b.v_out_model = 25'sh0000123;
    for (int i = 0; i < 14; i++) begin
      b.go_vio = (i < 2);
      tick;
      if (b.model_ce) begin
        nce++;
        if (first < 0) first = i;
      end
      if (b.busy) nbusy++;
      if (upd < 0 && b.v_out_vio == 25'sh0000123) upd = i;
      if (i == 2) begin
        checks++;
        if (b.v_in_model !== ONE) begin
          failures++;
          $display("FAIL lat_v_in_model got=%0h exp=%0h", b.v_in_model, ONE);
        end
      end
    end
    checks++;
    if (first != 2) begin failures++; $display("FAIL lat_ce_edge got=%0d exp=2", first); end
    checks++;
    if (nce != 1) begin failures++; $display("FAIL lat_ce_count got=%0d exp=1", nce); end
    checks++;
    if (nbusy != 6) begin failures++; $display("FAIL lat_busy_cycles got=%0d exp=6", nbusy); end
    checks++;
    if (upd != 8) begin failures++; $display("FAIL lat_capture_edge got=%0d exp=8", upd); end
    checks++;
    if (b.step_count !== 0 || b.model_rst !== 1'b1) begin
      failures++;
      $display("FAIL lat_rst_hold got cnt=%0d mrst=%0d exp cnt=0 mrst=1", b.step_count, b.model_rst);
    end
  endtask
  task automatic test_counting;
    int nce = 0;
    b.rst_vio = 1'b0;
    repeat (4) tick;
    checks++;
    if (b.model_rst !== 1'b0) begin failures++; $display("FAIL cnt_model_rst got=%0d exp=0", b.model_rst); end
    for (int p = 0; p < 25; p++) begin
      b.v_out_model = W'(p * 1000 + 7);
      b.v_in_vio = W'(p * 3);
      for (int i = 0; i < 20; i++) begin
        b.go_vio = (i < 2);
        tick;
        if (b.model_ce) nce++;
      end
      checks++;
      if (b.v_out_vio !== W'(p * 1000 + 7)) begin
        failures++;
        $display("FAIL cnt_v_out_vio step=%0d got=%0h exp=%0h", p, b.v_out_vio, W'(p * 1000 + 7));
      end
    end
    checks++;
    if (nce != 25) begin failures++; $display("FAIL cnt_ce_pulses got=%0d exp=25", nce); end
    checks++;
    if (b.step_count !== 25) begin failures++; $display("FAIL cnt_step_count got=%0d exp=25", b.step_count); end
    checks++;
    if (b.missed_go !== 1'b0) begin failures++; $display("FAIL cnt_missed got=%0d exp=0", b.missed_go); end
  endtask
  task automatic test_overlap;
    int nce = 0;
    for (int i = 0; i < 20; i++) begin
      b.go_vio = (i == 0 || i == 3);
      tick;
      if (b.model_ce) nce++;
    end
    checks++;
    if (nce != 1) begin failures++; $display("FAIL ovl_ce_pulses got=%0d exp=1", nce); end
    checks++;
    if (b.missed_go !== 1'b1) begin failures++; $display("FAIL ovl_missed_set got=%0d exp=1", b.missed_go); end
    checks++;
    if (b.step_count !== 26) begin failures++; $display("FAIL ovl_step_count got=%0d exp=26", b.step_count); end
    b.rst_vio = 1'b1;
    repeat (4) tick;
    checks++;
    if (b.missed_go !== 1'b0 || b.step_count !== 0) begin
      failures++;
      $display("FAIL ovl_rst_clear got missed=%0d cnt=%0d exp 0 0", b.missed_go, b.step_count);
    end
    b.rst_vio = 1'b0;
    repeat (4) tick;
  endtask
  task automatic test_stim_hold;
    b.v_in_vio = HALF;
    for (int i = 0; i < 20; i++) begin
      b.go_vio = (i < 2);
      if (i == 5) b.v_in_vio = QNEG;
      tick;
      if (i == 6) begin
        checks++;
        if (b.v_in_model !== HALF) begin failures++; $display("FAIL hold_mid got=%0h exp=%0h", b.v_in_model, HALF); end
      end
    end
    checks++;
    if (b.v_in_model !== HALF) begin failures++; $display("FAIL hold_after got=%0h exp=%0h", b.v_in_model, HALF); end
    for (int i = 0; i < 20; i++) begin
      b.go_vio = (i < 2);
      tick;
    end
    checks++;
    if (b.v_in_model !== QNEG) begin failures++; $display("FAIL hold_reload got=%0h exp=%0h", b.v_in_model, QNEG); end
  endtask
  task automatic test_reset_mid;
    int nce = 0, nbusy = 0;
    b.v_in_vio = ONE;
    for (int i = 0; i < 5; i++) begin
      b.go_vio = 1'b1;
      tick;
    end
    checks++;
    if (b.busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%0d exp=1", b.busy); end
    #3;
    emu_rst = 1'b1;
    #1;
    checks++;
    if ({b.model_rst, b.model_ce, b.busy, b.missed_go} !== 4'b1000) begin
      failures++;
      $display("FAIL mid_async_flags got=%b exp=1000", {b.model_rst, b.model_ce, b.busy, b.missed_go});
    end
    checks++;
    if (b.v_in_model !== 0 || b.v_out_vio !== 0 || b.step_count !== 0) begin
      failures++;
      $display("FAIL mid_async_data got vin=%0h vout=%0h cnt=%0d exp 0", b.v_in_model, b.v_out_vio, b.step_count);
    end
    repeat (2) tick;
    emu_rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (b.model_ce) nce++;
      if (b.busy) nbusy++;
    end
    checks++;
    if (nce != 0 || nbusy != 0) begin
      failures++;
      $display("FAIL mid_held_go got ce=%0d busy=%0d exp 0 0", nce, nbusy);
    end
    b.go_vio = 1'b0;
    repeat (4) tick;
    for (int i = 0; i < 15; i++) begin
      b.go_vio = (i < 2);
      tick;
      if (b.model_ce) nce++;
    end
    checks++;
    if (nce != 1) begin failures++; $display("FAIL mid_fresh_go got=%0d exp=1", nce); end
  endtask
  task automatic test_saturation;
    b4.rst_vio = 1'b0;
    repeat (4) tick;
    for (int p = 0; p < 17; p++) begin
      for (int i = 0; i < 12; i++) begin
        b4.go_vio = (i < 2);
        tick;
      end
      if (p == 13) begin
        checks++;
        if (b4.step_count !== 4'd14) begin failures++; $display("FAIL sat_before got=%0d exp=14", b4.step_count); end
      end
    end
    checks++;
    if (b4.step_count !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", b4.step_count); end
  endtask
  initial begin
    b.go_vio = 1'b0;
    b.rst_vio = 1'b1;
    b.v_in_vio = '0;
    b.v_out_model = '0;
    b4.go_vio = 1'b0;
    b4.rst_vio = 1'b1;
    b4.v_in_vio = '0;
    b4.v_out_model = 25'sh0000055;
    test_reset;
    test_latency;
    test_counting;
    test_overlap;
    test_stim_hold;
    test_reset_mid;
    test_saturation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
